// File: rtl/maze_pkg.sv
// Shared maze level data: state encoding, rectangle type and per-level path/finish/start tables.
// The pixel renderer reads the same tables, so both sides always agree on the level geometry.
package maze_pkg;

  localparam int SCREEN_W       = 640;
  localparam int SCREEN_H       = 480;
  localparam int NUM_PATH_RECTS = 4;

  typedef enum logic [2:0] {
    GS_IDLE  = 3'd0,
    GS_PLAY  = 3'd1,
    GS_CHECK = 3'd2,
    GS_HIT   = 3'd3,
    GS_WIN   = 3'd4,
    GS_OVER  = 3'd5
  } game_state_t;

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    logic [9:0] w;
    logic [8:0] h;
  } rect_t;

  function automatic rect_t mk_rect(input int rx, input int ry, input int rw, input int rh);
    rect_t r;
    r.x = 10'(rx);
    r.y = 9'(ry);
    r.w = 10'(rw);
    r.h = 9'(rh);
    return r;
  endfunction

  // A zero-width rectangle never contains a point, so it pads short levels.
  function automatic rect_t path_rect(input logic [1:0] lvl, input logic [1:0] idx);
    rect_t r;
    case ({lvl, idx})
      4'h0:    r = mk_rect(0, 200, 320, 80);
      4'h1:    r = mk_rect(320, 100, 80, 280);
      4'h2:    r = mk_rect(400, 100, 240, 80);
      4'h4:    r = mk_rect(0, 60, 120, 360);
      4'h5:    r = mk_rect(120, 300, 280, 60);
      4'h6:    r = mk_rect(400, 60, 60, 300);
      4'h7:    r = mk_rect(460, 60, 180, 60);
      4'h8:    r = mk_rect(0, 90, 160, 300);
      4'h9:    r = mk_rect(160, 140, 120, 200);
      4'hA:    r = mk_rect(280, 190, 120, 100);
      4'hB:    r = mk_rect(400, 220, 220, 35);
      default: r = mk_rect(0, 0, 0, 0);
    endcase
    return r;
  endfunction

  function automatic rect_t finish_rect(input logic [1:0] lvl);
    rect_t r;
    case (lvl)
      2'd1:    r = mk_rect(600, 60, 40, 60);
      2'd2:    r = mk_rect(600, 220, 50, 35);
      default: r = mk_rect(560, 100, 80, 80);
    endcase
    return r;
  endfunction

  function automatic logic [9:0] level_start_x(input logic [1:0] lvl);
    logic [9:0] sx;
    case (lvl)
      2'd1:    sx = 10'd20;
      2'd2:    sx = 10'd20;
      default: sx = 10'd20;
    endcase
    return sx;
  endfunction

  function automatic logic [8:0] level_start_y(input logic [1:0] lvl);
    logic [8:0] sy;
    case (lvl)
      2'd1:    sy = 9'd236;
      2'd2:    sy = 9'd236;
      default: sy = 9'd236;
    endcase
    return sy;
  endfunction

  // Half-open containment: x in [r.x, r.x+r.w), y in [r.y, r.y+r.h).
  function automatic logic pt_in_rect(input logic [9:0] px, input logic [8:0] py, input rect_t r);
    logic [10:0] x_end;
    logic [9:0]  y_end;
    x_end = {1'b0, r.x} + {1'b0, r.w};
    y_end = {1'b0, r.y} + {1'b0, r.h};
    return (px >= r.x) && ({1'b0, px} < x_end) && (py >= r.y) && ({1'b0, py} < y_end);
  endfunction

endpackage

// File: rtl/maze_path_lookup.sv
// Combinational point classifier for the active level: on any path rectangle (or the finish),
// and inside the finish rectangle. Zero latency, no flow control.
module maze_path_lookup
  import maze_pkg::*;
(
  input  logic [1:0] i_level,
  input  logic [9:0] i_x,
  input  logic [8:0] i_y,
  output logic       o_on_path,
  output logic       o_in_finish
);

  logic w_in_path;

  always_comb begin
    w_in_path = 1'b0;
    for (int i = 0; i < NUM_PATH_RECTS; i++) begin
      if (pt_in_rect(i_x, i_y, path_rect(i_level, 2'(i)))) w_in_path = 1'b1;
    end
  end

  assign o_in_finish = pt_in_rect(i_x, i_y, finish_rect(i_level));
  assign o_on_path   = w_in_path | o_in_finish;

endmodule

// File: rtl/maze_level_sequencer.sv
// Maze game controller: moves the player on synchronised buttons each move tick, checks the four
// candidate corners one per cycle (commit 5 cycles after the tick) and sequences lives and levels.
module maze_level_sequencer
  import maze_pkg::*;
#(
  parameter int MOVE_DIV    = 416667,
  parameter int STEP        = 2,
  parameter int PLAYER_SIZE = 8,
  parameter int NUM_LEVELS  = 3,
  parameter int LIVES       = 3,
  parameter int START_LEVEL = 0
) (
  input  logic       pixel_clk,
  input  logic       resetSwitch,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_start,
  output logic [9:0] player_x,
  output logic [8:0] player_y,
  output logic [1:0] level_idx,
  output logic [2:0] game_state,
  output logic [1:0] lives_left,
  output logic       hit_pulse
);

  localparam int                 TICK_W     = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(MOVE_DIV - 1);
  localparam logic signed [11:0] STEP_S     = 12'(STEP);
  localparam logic signed [11:0] MAX_X_S    = 12'(SCREEN_W - PLAYER_SIZE);
  localparam logic signed [11:0] MAX_Y_S    = 12'(SCREEN_H - PLAYER_SIZE);
  localparam logic [9:0]         CORNER_DX  = 10'(PLAYER_SIZE - 1);
  localparam logic [8:0]         CORNER_DY  = 9'(PLAYER_SIZE - 1);
  localparam logic [1:0]         START_LVL  = 2'(START_LEVEL);
  localparam logic [1:0]         LAST_LVL   = 2'(NUM_LEVELS - 1);
  localparam logic [1:0]         LIVES_INIT = 2'(LIVES);

  localparam logic [2:0] S_IDLE  = GS_IDLE;
  localparam logic [2:0] S_PLAY  = GS_PLAY;
  localparam logic [2:0] S_CHECK = GS_CHECK;
  localparam logic [2:0] S_HIT   = GS_HIT;
  localparam logic [2:0] S_WIN   = GS_WIN;
  localparam logic [2:0] S_OVER  = GS_OVER;

  // Button vector order: {up, down, left, right, start}.
  logic [4:0]        r_btn_s1;
  logic [4:0]        r_btn_s2;
  logic              r_start_d;
  logic [TICK_W-1:0] r_tick;
  logic [2:0]        r_state;
  logic [1:0]        r_level;
  logic [1:0]        r_lives;
  logic [9:0]        r_px;
  logic [8:0]        r_py;
  logic [9:0]        r_cx;
  logic [8:0]        r_cy;
  logic [1:0]        r_corner;
  logic              r_fin_seen;

  logic              w_up, w_down, w_left, w_right;
  logic              w_start_edge;
  logic              w_move_tick;
  logic signed [11:0] w_dx, w_dy, w_nx, w_ny;
  logic [9:0]        w_cand_x;
  logic [8:0]        w_cand_y;
  logic              w_dir_nz;
  logic [9:0]        w_qx;
  logic [8:0]        w_qy;
  logic              w_on_path;
  logic              w_in_finish;

  assign w_up         = r_btn_s2[4];
  assign w_down       = r_btn_s2[3];
  assign w_left       = r_btn_s2[2];
  assign w_right      = r_btn_s2[1];
  assign w_start_edge = r_btn_s2[0] & ~r_start_d;
  assign w_move_tick  = (r_tick == TICK_LAST);

  // Opposing buttons cancel; the candidate saturates at the screen edges instead of wrapping.
  always_comb begin
    w_dx = '0;
    w_dy = '0;
    if (w_left && !w_right) w_dx = -STEP_S;
    else if (w_right && !w_left) w_dx = STEP_S;
    if (w_up && !w_down) w_dy = -STEP_S;
    else if (w_down && !w_up) w_dy = STEP_S;
    w_nx = $signed({2'b00, r_px}) + w_dx;
    w_ny = $signed({3'b000, r_py}) + w_dy;
    if (w_nx < 12'sd0) w_cand_x = '0;
    else if (w_nx > MAX_X_S) w_cand_x = MAX_X_S[9:0];
    else w_cand_x = w_nx[9:0];
    if (w_ny < 12'sd0) w_cand_y = '0;
    else if (w_ny > MAX_Y_S) w_cand_y = MAX_Y_S[8:0];
    else w_cand_y = w_ny[8:0];
  end

  assign w_dir_nz = (w_dx != 12'sd0) || (w_dy != 12'sd0);

  // Corner index bit 0 selects the right edge, bit 1 the bottom edge: TL, TR, BL, BR.
  always_comb begin
    w_qx = r_cx;
    w_qy = r_cy;
    if (r_corner[0]) w_qx = r_cx + CORNER_DX;
    if (r_corner[1]) w_qy = r_cy + CORNER_DY;
  end

  maze_path_lookup u_lookup (
    .i_level     (r_level),
    .i_x         (w_qx),
    .i_y         (w_qy),
    .o_on_path   (w_on_path),
    .o_in_finish (w_in_finish)
  );

  always_ff @(posedge pixel_clk or negedge resetSwitch) begin
    if (!resetSwitch) begin
      r_btn_s1  <= '0;
      r_btn_s2  <= '0;
      r_start_d <= 1'b0;
      r_tick    <= '0;
    end else begin
      r_btn_s1  <= {btn_up, btn_down, btn_left, btn_right, btn_start};
      r_btn_s2  <= r_btn_s1;
      r_start_d <= r_btn_s2[0];
      r_tick    <= w_move_tick ? '0 : r_tick + TICK_W'(1);
    end
  end

  always_ff @(posedge pixel_clk or negedge resetSwitch) begin
    if (!resetSwitch) begin
      r_state    <= S_IDLE;
      r_level    <= START_LVL;
      r_lives    <= LIVES_INIT;
      r_px       <= level_start_x(START_LVL);
      r_py       <= level_start_y(START_LVL);
      r_cx       <= level_start_x(START_LVL);
      r_cy       <= level_start_y(START_LVL);
      r_corner   <= '0;
      r_fin_seen <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start_edge) r_state <= S_PLAY;
        end
        S_PLAY: begin
          if (w_move_tick && w_dir_nz) begin
            r_cx       <= w_cand_x;
            r_cy       <= w_cand_y;
            r_corner   <= '0;
            r_fin_seen <= 1'b0;
            r_state    <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (!w_on_path) begin
            r_state <= S_HIT;
          end else if (r_corner == 2'd3) begin
            r_px    <= r_cx;
            r_py    <= r_cy;
            r_state <= (r_fin_seen || w_in_finish) ? S_WIN : S_PLAY;
          end else begin
            r_corner   <= r_corner + 2'd1;
            r_fin_seen <= r_fin_seen | w_in_finish;
          end
        end
        S_HIT: begin
          r_px <= level_start_x(r_level);
          r_py <= level_start_y(r_level);
          if (r_lives > 2'd1) begin
            r_lives <= r_lives - 2'd1;
            r_state <= S_PLAY;
          end else begin
            r_lives <= 2'd0;
            r_state <= S_OVER;
          end
        end
        S_WIN: begin
          // The last level is terminal until reset.
          if (w_start_edge && (r_level < LAST_LVL)) begin
            r_level <= r_level + 2'd1;
            r_px    <= level_start_x(r_level + 2'd1);
            r_py    <= level_start_y(r_level + 2'd1);
            r_state <= S_PLAY;
          end
        end
        S_OVER: begin
          if (w_start_edge) begin
            r_level <= START_LVL;
            r_lives <= LIVES_INIT;
            r_px    <= level_start_x(START_LVL);
            r_py    <= level_start_y(START_LVL);
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign player_x   = r_px;
  assign player_y   = r_py;
  assign level_idx  = r_level;
  assign game_state = r_state;
  assign lives_left = r_lives;
  assign hit_pulse  = (r_state == S_HIT);

endmodule

// File: tb/tb_maze_level_sequencer.sv
// Scoreboarded bench for maze_level_sequencer on level 2 with a 4-cycle move tick.
module tb_maze_level_sequencer;

  localparam int ST_IDLE  = 0;
  localparam int ST_PLAY  = 1;
  localparam int ST_CHECK = 2;
  localparam int ST_HIT   = 3;
  localparam int ST_WIN   = 4;
  localparam int ST_OVER  = 5;

  logic       pixel_clk;
  logic       resetSwitch;
  logic       btn_up, btn_down, btn_left, btn_right, btn_start;
  logic [9:0] player_x;
  logic [8:0] player_y;
  logic [1:0] level_idx;
  logic [2:0] game_state;
  logic [1:0] lives_left;
  logic       hit_pulse;

  maze_level_sequencer #(
    .MOVE_DIV    (4),
    .START_LEVEL (2)
  ) dut (
    .pixel_clk   (pixel_clk),
    .resetSwitch (resetSwitch),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .btn_start   (btn_start),
    .player_x    (player_x),
    .player_y    (player_y),
    .level_idx   (level_idx),
    .game_state  (game_state),
    .lives_left  (lives_left),
    .hit_pulse   (hit_pulse)
  );

  typedef struct {
    bit hit;
    int x;
    int y;
    int lives;
    int st;
    int gap;
  } evt_t;

  evt_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   last_move_cyc = 0;
  int   prev_x = 0;
  int   prev_y = 0;
  bit   mon_en = 0;

  initial begin
    pixel_clk = 1'b0;
    forever #5 pixel_clk = ~pixel_clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic push_evt(input bit hit, input int x, input int y, input int lives,
                          input int st, input int gap);
    evt_t e;
    e.hit = hit; e.x = x; e.y = y; e.lives = lives; e.st = st; e.gap = gap;
    sb_q.push_back(e);
  endtask

  task automatic sb_compare(input bit is_hit);
    evt_t e;
    check_eq("sb_has_entry", int'(sb_q.size() != 0), 1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check_eq("evt_kind", int'(is_hit), int'(e.hit));
      check_eq("evt_x", int'(player_x), e.x);
      check_eq("evt_y", int'(player_y), e.y);
      check_eq("evt_lives", int'(lives_left), e.lives);
      check_eq("evt_state", int'(game_state), e.st);
      if (!is_hit && e.gap >= 0) check_eq("evt_move_gap", cyc - last_move_cyc, e.gap);
    end
  endtask

  // Events: every hit_pulse cycle, and every cycle the player position changes.
  always @(negedge pixel_clk) begin
    cyc <= cyc + 1;
    if (resetSwitch && mon_en) begin
      if (hit_pulse) sb_compare(1'b1);
      if (int'(player_x) != prev_x || int'(player_y) != prev_y) begin
        sb_compare(1'b0);
        last_move_cyc <= cyc;
      end
    end
    prev_x <= int'(player_x);
    prev_y <= int'(player_y);
  end

  task automatic wait_state(input string tag, input int st, input int budget);
    int n = 0;
    while (int'(game_state) != st && n < budget) begin
      @(negedge pixel_clk);
      n++;
    end
    check_eq(tag, int'(game_state), st);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(negedge pixel_clk);
      n++;
    end
    check_eq(tag, sb_q.size(), 0);
  endtask

  task automatic pulse_start();
    btn_start = 1'b1;
    repeat (4) @(negedge pixel_clk);
    btn_start = 1'b0;
    repeat (3) @(negedge pixel_clk);
  endtask

  initial begin
    btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_start = 0;
    resetSwitch = 1'b0;
    repeat (3) @(negedge pixel_clk);
    check_eq("rst_state", int'(game_state), ST_IDLE);
    check_eq("rst_x", int'(player_x), 20);
    check_eq("rst_y", int'(player_y), 236);
    check_eq("rst_lives", int'(lives_left), 3);
    check_eq("rst_level", int'(level_idx), 2);
    check_eq("rst_hit", int'(hit_pulse), 0);
    resetSwitch = 1'b1;
    mon_en = 1'b1;
    repeat (6) @(negedge pixel_clk);
    check_eq("idle_hold_state", int'(game_state), ST_IDLE);

    // Start edge through the synchroniser
    btn_start = 1'b1;
    wait_state("start_to_play", ST_PLAY, 6);
    repeat (3) @(negedge pixel_clk);
    btn_start = 1'b0;
    repeat (3) @(negedge pixel_clk);

    // Run right along the corridor into the finish
    for (int x = 22; x <= 594; x += 2)
      push_evt(0, x, 236, 3, (x == 594) ? ST_WIN : ST_PLAY, (x == 22) ? -1 : 8);
    btn_right = 1'b1;
    wait_drain("right_run_drain", 3000);
    check_eq("win_state", int'(game_state), ST_WIN);
    check_eq("win_x", int'(player_x), 594);
    btn_right = 1'b0;
    pulse_start();
    repeat (4) @(negedge pixel_clk);
    check_eq("last_level_stays_win", int'(game_state), ST_WIN);
    check_eq("last_level_idx", int'(level_idx), 2);

    resetSwitch = 1'b0;
    repeat (2) @(negedge pixel_clk);
    resetSwitch = 1'b1;
    repeat (2) @(negedge pixel_clk);
    check_eq("rst2_x", int'(player_x), 20);

    // Hold up: each run hits the top of the first rectangle; three hits end the game
    pulse_start();
    check_eq("play_again", int'(game_state), ST_PLAY);
    for (int r = 0; r < 3; r++) begin
      for (int y = 234; y >= 90; y -= 2)
        push_evt(0, 20, y, 3 - r, ST_PLAY, (y == 234) ? -1 : 8);
      push_evt(1, 20, 90, 3 - r, ST_HIT, -1);
      push_evt(0, 20, 236, 2 - r, (r == 2) ? ST_OVER : ST_PLAY, -1);
    end
    btn_up = 1'b1;
    wait_drain("up_hits_drain", 2500);
    check_eq("over_state", int'(game_state), ST_OVER);
    check_eq("over_lives", int'(lives_left), 0);
    btn_up = 1'b0;
    repeat (4) @(negedge pixel_clk);
    btn_start = 1'b1;
    wait_state("over_to_idle", ST_IDLE, 8);
    btn_start = 1'b0;
    repeat (3) @(negedge pixel_clk);
    check_eq("idle_lives", int'(lives_left), 3);
    check_eq("idle_level", int'(level_idx), 2);

    // Left edge clamp, then cancelling buttons
    pulse_start();
    for (int x = 18; x >= 0; x -= 2) push_evt(0, x, 236, 3, ST_PLAY, (x == 18) ? -1 : 8);
    btn_left = 1'b1;
    wait_drain("left_run_drain", 200);
    repeat (80) @(negedge pixel_clk);
    btn_left = 1'b0;
    repeat (16) @(negedge pixel_clk);
    check_eq("clamp_x", int'(player_x), 0);
    check_eq("clamp_state", int'(game_state), ST_PLAY);
    btn_left = 1'b1;
    btn_right = 1'b1;
    repeat (60) @(negedge pixel_clk);
    check_eq("lr_cancel_x", int'(player_x), 0);
    check_eq("lr_cancel_lives", int'(lives_left), 3);
    btn_left = 1'b0;
    btn_right = 1'b0;
    repeat (16) @(negedge pixel_clk);
    check_eq("lr_cancel_state", int'(game_state), ST_PLAY);

    // Asynchronous reset in the middle of a corner check
    btn_right = 1'b1;
    wait_state("reach_check", ST_CHECK, 40);
    resetSwitch = 1'b0;
    #1;
    check_eq("arst_state", int'(game_state), ST_IDLE);
    check_eq("arst_x", int'(player_x), 20);
    check_eq("arst_y", int'(player_y), 236);
    check_eq("arst_lives", int'(lives_left), 3);
    check_eq("arst_level", int'(level_idx), 2);
    check_eq("arst_hit", int'(hit_pulse), 0);
    btn_right = 1'b0;
    repeat (2) @(negedge pixel_clk);
    resetSwitch = 1'b1;
    repeat (12) @(negedge pixel_clk);
    check_eq("post_arst_x", int'(player_x), 20);
    check_eq("post_arst_state", int'(game_state), ST_IDLE);
    check_eq("sb_final_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
